// File: rtl/rst_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rst_seq : lock-qualified ordered release of peripheral then core reset.
// Rev 1.0
// ---------------------------------------------------------------------------
module rst_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CORE_DELAY_CYCLES  = 16,
  parameter int SW_RST_CYCLES      = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  input  logic       sw_rst_req_i,
  output logic       periph_rst_o,
  output logic       core_rst_o,
  output logic       ready_o,
  output logic [7:0] lock_loss_cnt_o,
  output logic [2:0] state_o
);

  localparam int MAX_AB  = (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ?
                           LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
  localparam int MAX_CNT = (MAX_AB > SW_RST_CYCLES) ? MAX_AB : SW_RST_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_RST_CYCLES - 1);

  localparam logic [2:0] WAIT_LOCK  = 3'd0;
  localparam logic [2:0] STABLE     = 3'd1;
  localparam logic [2:0] REL_PERIPH = 3'd2;
  localparam logic [2:0] RUN        = 3'd3;
  localparam logic [2:0] SW_RST     = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   periph_q, periph_d;
  logic                   core_q, core_d;
  logic                   ready_q, ready_d;
  logic [7:0]             loss_q, loss_d;
  logic                   lost;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost    = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = REL_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REL_PERIPH: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lost    = 1'b1;
        end else if (cnt_q == CORE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lost    = 1'b1;
        end else if (sw_rst_req_i) begin
          state_d = SW_RST;
          cnt_d   = '0;
        end
      end
      SW_RST: begin
        // Lock was held throughout, so the stability wait is skipped.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lost    = 1'b1;
        end else if (cnt_q == SW_LAST) begin
          state_d = REL_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the transition edge.
  always_comb begin
    periph_d = (state_d != REL_PERIPH) && (state_d != RUN);
    core_d   = (state_d != RUN);
    ready_d  = (state_d == RUN);
    loss_d   = loss_q;
    if (lost && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      core_q   <= 1'b1;
      ready_q  <= 1'b0;
      loss_q   <= 8'd0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], locked_i};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      ready_q  <= ready_d;
      loss_q   <= loss_d;
    end
  end

  assign periph_rst_o    = periph_q;
  assign core_rst_o      = core_q;
  assign ready_o         = ready_q;
  assign lock_loss_cnt_o = loss_q;
  assign state_o         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rst_seq : directed self-checking bench for rst_seq (2/8/4/3 config).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rst_seq;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       locked_i;
  logic       sw_rst_req_i;
  logic       periph_rst_o;
  logic       core_rst_o;
  logic       ready_o;
  logic [7:0] lock_loss_cnt_o;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  rst_seq #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .CORE_DELAY_CYCLES (4),
    .SW_RST_CYCLES     (3)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .locked_i       (locked_i),
    .sw_rst_req_i   (sw_rst_req_i),
    .periph_rst_o   (periph_rst_o),
    .core_rst_o     (core_rst_o),
    .ready_o        (ready_o),
    .lock_loss_cnt_o(lock_loss_cnt_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  int exp_st;
  int exp_loss;

  initial begin
    rst_i        = 1'b1;
    locked_i     = 1'b1;
    sw_rst_req_i = 1'b0;
    tick();
    tick();
    check("rst_state",  state_o, 0);
    check("rst_periph", periph_rst_o, 1);
    check("rst_core",   core_rst_o, 1);
    check("rst_ready",  ready_o, 0);
    check("rst_loss",   lock_loss_cnt_o, 0);

    // Power-up with lock already present
    rst_i = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      exp_st = (e < 3) ? 0 : (e < 11) ? 1 : (e < 15) ? 2 : 3;
      check("pwr_state",  state_o, exp_st);
      check("pwr_periph", periph_rst_o, (e < 11) ? 1 : 0);
      check("pwr_core",   core_rst_o, (e < 15) ? 1 : 0);
      check("pwr_ready",  ready_o, (e < 15) ? 0 : 1);
    end
    check("pwr_loss", lock_loss_cnt_o, 0);

    // Unstable lock: high 5, low 2, then high
    locked_i = 1'b0;
    do_reset();
    for (int e = 1; e <= 22; e++) begin
      locked_i = ((e <= 5) || (e >= 8)) ? 1'b1 : 1'b0;
      tick();
      exp_st = (e < 3) ? 0 : (e < 8) ? 1 : (e < 10) ? 0 : (e < 18) ? 1 : (e < 22) ? 2 : 3;
      check("unst_state",  state_o, exp_st);
      check("unst_periph", periph_rst_o, (e < 18) ? 1 : 0);
    end
    check("unst_ready", ready_o, 1);
    check("unst_loss",  lock_loss_cnt_o, 0);

    // Software reset pulse in RUN
    sw_rst_req_i = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      sw_rst_req_i = 1'b0;
      exp_st = (k < 3) ? 4 : (k < 7) ? 2 : 3;
      check("sw_state",  state_o, exp_st);
      check("sw_periph", periph_rst_o, (k < 3) ? 1 : 0);
      check("sw_core",   core_rst_o, (k < 7) ? 1 : 0);
      check("sw_ready",  ready_o, (k < 7) ? 0 : 1);
    end

    // Lock loss in RUN, then regain
    locked_i = 1'b0;
    tick();
    tick();
    check("loss_hold_ready", ready_o, 1);
    tick();
    check("loss_state",  state_o, 0);
    check("loss_periph", periph_rst_o, 1);
    check("loss_core",   core_rst_o, 1);
    check("loss_ready",  ready_o, 0);
    check("loss_cnt",    lock_loss_cnt_o, 1);
    locked_i = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e == 3)  check("regain_stable", state_o, 1);
      if (e == 10) check("regain_periph_hold", periph_rst_o, 1);
      if (e == 11) check("regain_periph_rel", periph_rst_o, 0);
      if (e == 14) check("regain_ready_lo", ready_o, 0);
      if (e == 15) check("regain_ready_hi", ready_o, 1);
    end

    // Software request coincident with synchronised lock loss
    locked_i = 1'b0;
    tick();
    tick();
    check("coin_pre_state", state_o, 3);
    sw_rst_req_i = 1'b1;
    tick();
    sw_rst_req_i = 1'b0;
    check("coin_state", state_o, 0);
    check("coin_cnt",   lock_loss_cnt_o, 2);

    // 260 further loss events from REL_PERIPH: counter saturates
    exp_loss = 2;
    for (int i = 0; i < 260; i++) begin
      locked_i = 1'b1;
      repeat (11) tick();
      if (i == 0) check("sat_relp", state_o, 2);
      locked_i = 1'b0;
      repeat (3) tick();
      exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
      check("sat_cnt", lock_loss_cnt_o, exp_loss);
    end

    // Asynchronous reset in REL_PERIPH
    locked_i = 1'b1;
    repeat (12) tick();
    check("arst_pre_state", state_o, 2);
    check("arst_pre_periph", periph_rst_o, 0);
    #3;
    rst_i = 1'b1;
    #1;
    check("arst_state",  state_o, 0);
    check("arst_periph", periph_rst_o, 1);
    check("arst_core",   core_rst_o, 1);
    check("arst_ready",  ready_o, 0);
    check("arst_loss",   lock_loss_cnt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer that consumes the clock generator's lock indication and produces ordered reset releases for the design.
- Synchronises the asynchronous lock flag and waits for a stable lock.
- Releases the peripheral reset, then the core reset after a delay.
- Supports a software-requested warm reset and re-asserts all resets on lock loss.
- Sits directly downstream of the clock generator, clocked by the generated system clock.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the locked_i synchroniser (legal range ≥2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before the peripheral reset is released (≥1).
- CORE_DELAY_CYCLES, 16, cycles between the peripheral reset release and the core reset release (≥1).
- SW_RST_CYCLES, 8, cycles both resets are held for a software reset (≥1).

Ports:
- clk_i  input  1  system clock (generated clock output).
- rst_i  input  1  asynchronous, active-high reset.
- locked_i  input  1  clock generator lock flag; asynchronous to clk_i.
- sw_rst_req_i  input  1  synchronous software reset request, sampled each cycle.
- periph_rst_o  output  1  active-high peripheral reset.
- core_rst_o  output  1  active-high core reset.
- ready_o  output  1  high when both resets are released.
- lock_loss_cnt_o  output  8  saturating count of lock losses after release began.
- state_o  output  3  current FSM state (debug).

Behaviour:
- One clock; reset is asynchronous and active-high. rst_i asserts all state immediately.
- Reset values:
  - state = WAIT_LOCK.
  - periph_rst_o = 1, core_rst_o = 1, ready_o = 0.
  - lock_loss_cnt_o = 0; synchroniser flops = 0; counter = 0.
- Synchroniser: locked_s is locked_i passed through SYNC_STAGES flops. Only locked_s is used internally.
- State encoding: WAIT_LOCK = 0, STABLE = 1, REL_PERIPH = 2, RUN = 3, SW_RST = 4. Encodings 5–7 are unreachable and recover to WAIT_LOCK.
- All outputs are registered and change on the same edge as the state transition.
- Single shared counter cnt, width $clog2(max(LOCK_STABLE_CYCLES, CORE_DELAY_CYCLES, SW_RST_CYCLES) + 1). It is cleared on every state entry.
- WAIT_LOCK: both resets = 1, ready = 0. If locked_s = 1, go to STABLE.
- STABLE: both resets = 1.
  - If locked_s = 0, go to WAIT_LOCK; no loss is counted.
  - Else if cnt == LOCK_STABLE_CYCLES-1, go to REL_PERIPH.
  - Else cnt++.
- REL_PERIPH: periph_rst_o = 0, core_rst_o = 1, ready = 0.
  - If cnt == CORE_DELAY_CYCLES-1, go to RUN.
  - Else cnt++.
- RUN: both resets = 0, ready = 1.
  - If sw_rst_req_i = 1, go to SW_RST.
- SW_RST: both resets = 1, ready = 0.
  - If cnt == SW_RST_CYCLES-1, go to REL_PERIPH. The STABLE wait is skipped because lock was held.
  - Else cnt++.
- Lock loss: locked_s = 0 in REL_PERIPH, RUN or SW_RST forces WAIT_LOCK on that edge.
  - Resets assert and ready drops on that edge.
  - lock_loss_cnt_o increments, saturating at 255.
- Priority: lock loss > software request > counter expiry.
- sw_rst_req_i is ignored outside RUN. Holding it high in RUN re-enters SW_RST after each REL_PERIPH→RUN pass.
- Latency, locked_i high and stable (edges counted from the first edge that samples it high):
  - periph_rst_o falls at edge SYNC_STAGES+1+LOCK_STABLE_CYCLES.
  - core_rst_o falls and ready_o rises CORE_DELAY_CYCLES edges later.
- Lock-loss latency: resets assert SYNC_STAGES+1 edges after the first edge sampling locked_i low.
- Glitches on locked_i shorter than one cycle may or may not be captured. Either outcome must leave the FSM in a legal state.
- rst_i mid-sequence returns to the reset values at once. lock_loss_cnt_o clears.

Test Plan (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, CORE_DELAY_CYCLES=4, SW_RST_CYCLES=3):
1. Power-up: locked_i=1 before rst_i falls.
   - periph_rst_o falls at edge 11, core_rst_o falls and ready_o rises at edge 15, state_o goes 0→1→2→3.
   - lock_loss_cnt_o stays 0.
2. Unstable lock: locked_i high 5 cycles, low 2, then high.
   - STABLE aborts to WAIT_LOCK, periph_rst_o never falls early.
   - The full 8-cycle count restarts and lock_loss_cnt_o stays 0.
3. Software reset: in RUN pulse sw_rst_req_i for 1 cycle.
   - Both resets high for 3 cycles, then periph_rst_o low, then core_rst_o low 4 cycles later; ready_o back to 1.
4. Lock loss: in RUN drop locked_i.
   - Both resets high and ready_o low 3 edges later; lock_loss_cnt_o=1.
   - Regain lock: full sequence repeats.
5. Simultaneous events and saturation:
   - sw_rst_req_i and lock loss on the same edge in RUN: state goes to WAIT_LOCK and the count increments.
   - 260 loss events: lock_loss_cnt_o saturates at 255.
6. Mid-operation reset: assert rst_i asynchronously while in REL_PERIPH.
   - Outputs return to reset values without waiting for a clock edge; lock_loss_cnt_o=0.
